// File: rtl/sector_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sector_responder
// Description : Issues one SD sector read per request and routes the 512
//               streamed bytes by selector: directory cluster field, FAT
//               cluster entry (may straddle sectors), song data to a FIFO,
//               or discard.
//               Optional macro XFER_COUNT_EN adds sectors_read/dropped_req
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sector_responder #(
  parameter int DIR_OFS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_address,
  input  logic [31:0] SDaddress,
  input  logic [1:0]  selector,
  input  logic [31:0] target_byte,
  input  logic [31:0] cluster_offset,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  output logic        done,
  output logic        valid_directory,
  output logic [15:0] directory_data,
  output logic        valid_cluster,
  output logic [23:0] cluster_data,
  output logic        fifo_wr,
  output logic [7:0]  fifo_byte
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0] sectors_read,
  output logic [7:0]  dropped_req
`endif
);

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ISSUE  = 3'd2,
    S_STREAM = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [1:0] c_sel_dir  = 2'd0;
  localparam logic [1:0] c_sel_fat  = 2'd1;
  localparam logic [1:0] c_sel_song = 2'd2;
  localparam logic [8:0] c_last_idx = 9'd511;
  localparam logic [8:0] c_dir_hi   = 9'(DIR_OFS + 26);
  localparam logic [8:0] c_dir_lo   = 9'(DIR_OFS + 27);

  state_t     r_state;
  logic [1:0] r_sel;
  logic [8:0] r_target;
  logic [1:0] r_count;
  logic [8:0] r_index;
  logic [1:0] r_collected;
  logic       r_avail_q;

  logic       w_edge;
  logic [9:0] w_win_end;
  logic       w_in_window;
  logic       w_unused;

  // New byte: level went high since the previous clock
  assign w_edge      = sd_byte_available & ~r_avail_q;
  // FAT window is [target, target+count); 10 bits so it can run past 511
  assign w_win_end   = {1'b0, r_target} + {8'd0, r_count};
  assign w_in_window = ({1'b0, r_index} >= {1'b0, r_target}) &&
                       ({1'b0, r_index} <  w_win_end);
  // Only the low bits of these request fields carry meaning
  assign w_unused    = &{1'b0, target_byte[31:9], cluster_offset[31:2]};

  // Main request/stream state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_BOOT;
      r_sel           <= 2'd0;
      r_target        <= 9'd0;
      r_count         <= 2'd0;
      r_index         <= 9'd0;
      r_collected     <= 2'd0;
      r_avail_q       <= 1'b0;
      sd_rd           <= 1'b0;
      sd_address      <= 32'd0;
      done            <= 1'b0;
      valid_directory <= 1'b0;
      directory_data  <= 16'd0;
      valid_cluster   <= 1'b0;
      cluster_data    <= 24'd0;
      fifo_wr         <= 1'b0;
      fifo_byte       <= 8'd0;
    end else begin
      done            <= 1'b0;
      valid_directory <= 1'b0;
      valid_cluster   <= 1'b0;
      fifo_wr         <= 1'b0;
      r_avail_q       <= sd_byte_available;
      case (r_state)
        S_BOOT: begin
          if (sd_ready) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (valid_address) begin
            r_sel      <= selector;
            r_target   <= target_byte[8:0];
            // An offset of zero means a full three-byte entry
            r_count    <= (cluster_offset[1:0] == 2'd0) ? 2'd3 : cluster_offset[1:0];
            sd_address <= SDaddress;
            sd_rd      <= 1'b1;
            // Only back-to-back FAT reads may continue a straddling entry
            if (selector != c_sel_fat) r_collected <= 2'd0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Controller dropping ready is the acknowledge of the read strobe
          if (!sd_ready) begin
            sd_rd   <= 1'b0;
            r_index <= 9'd0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_edge) begin
            if (r_sel == c_sel_song) begin
              fifo_wr   <= 1'b1;
              fifo_byte <= sd_dout;
            end
            if (r_sel == c_sel_dir) begin
              if (r_index == c_dir_hi) directory_data[15:8] <= sd_dout;
              if (r_index == c_dir_lo) directory_data[7:0]  <= sd_dout;
            end
            if ((r_sel == c_sel_fat) && w_in_window) begin
              cluster_data <= {cluster_data[15:0], sd_dout};
              if (r_collected != 2'd3) r_collected <= r_collected + 2'd1;
            end
            if (r_index == c_last_idx) r_state <= S_FINISH;
            else                       r_index <= r_index + 9'd1;
          end
        end
        S_FINISH: begin
          if (sd_ready) begin
            done <= 1'b1;
            if (r_sel == c_sel_dir) valid_directory <= 1'b1;
            if ((r_sel == c_sel_fat) && (r_collected == 2'd3)) begin
              valid_cluster <= 1'b1;
              r_collected   <= 2'd0;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

`ifdef XFER_COUNT_EN
  // Transfer statistics: completed sectors (wrapping) and ignored requests (saturating)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sectors_read <= 16'd0;
      dropped_req  <= 8'd0;
    end else begin
      if ((r_state == S_FINISH) && sd_ready) sectors_read <= sectors_read + 16'd1;
      if (valid_address && (r_state != S_IDLE) && (dropped_req != 8'hFF))
        dropped_req <= dropped_req + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/sector_responder.md
SECTOR_RESPONDER -- requirements
Module: sector_responder

Interface
REQ-001 clk  input  1  25 MHz system clock, all logic on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 valid_address  input  1  one-cycle read request from the filesystem walker.
REQ-004 SDaddress  input  32  byte address of the sector to read.
REQ-005 selector  input  2  request kind: 0 directory, 1 FAT cluster entry, 2 song data, 3 discard.
REQ-006 target_byte  input  32  first byte index within the sector (selector 1 only); bits [8:0] used.
REQ-007 cluster_offset  input  32  number of FAT bytes to capture this read, 1..3 (selector 1 only); bits [1:0] used.
REQ-008 sd_ready  input  1  SD controller idle/ready.
REQ-009 sd_byte_available  input  1  level; each rising edge marks a new byte on sd_dout.
REQ-010 sd_dout  input  8  SD read byte.
REQ-011 sd_rd  output  1  SD read strobe.
REQ-012 sd_address  output  32  address presented to the SD controller.
REQ-013 done  output  1  one-cycle pulse: responder idle, ready for next request.
REQ-014 valid_directory  output  1  one-cycle pulse; directory_data valid.
REQ-015 directory_data  output  16  {byte[DIR_OFS+26], byte[DIR_OFS+27]}.
REQ-016 valid_cluster  output  1  one-cycle pulse; cluster_data valid.
REQ-017 cluster_data  output  24  three FAT bytes, first-captured byte in [23:16], last in [7:0].
REQ-018 fifo_wr  output  1  one-cycle pulse per data byte.
REQ-019 fifo_byte  output  8  data byte, valid with fifo_wr.
REQ-020 Parameter DIR_OFS, default 0, byte offset of the directory entry inside the sector (0..480, multiple of 32).

Function
REQ-021 States: BOOT, IDLE, ISSUE, STREAM, FINISH.
REQ-022 BOOT: on first cycle sd_ready=1, pulse done, go IDLE.
REQ-023 IDLE: valid_address=1 latches SDaddress, selector, target_byte[8:0], cluster_offset[1:0]; sd_address<=SDaddress; go ISSUE next cycle.
REQ-024 valid_address outside IDLE is ignored; no state change.
REQ-025 ISSUE: sd_rd=1 held until sd_ready samples 0, then sd_rd=0, byte index cleared, go STREAM.
REQ-026 STREAM: each sd_byte_available rising edge (registered-edge detect) captures sd_dout at current index, index increments; after index 511 go FINISH.
REQ-027 Selector 2: every byte produces fifo_wr one cycle after edge detect, 512 pulses per sector exactly.
REQ-028 Selector 0: bytes at DIR_OFS+26 and DIR_OFS+27 latched into directory_data[15:8] and [7:0].
REQ-029 Selector 1: bytes with target <= index < target+cluster_offset and index<=511 are shifted into cluster_data (shift left 8, new byte into [7:0]); collected counter increments per byte, saturating at 3.
REQ-030 Collected counter persists across consecutive selector 1 requests (sector-straddling entry); cleared on valid_cluster, on any non-1 request, and on reset.
REQ-031 FINISH: wait sd_ready=1, then in one cycle pulse done plus: valid_directory if selector 0; valid_cluster if selector 1 and collected=3; nothing extra otherwise; go IDLE.
REQ-032 Selector 1 with collected<3 at FINISH: done only (partial read), cluster_data retained.
REQ-033 Selector 3: sector consumed, no fifo_wr, done only.
REQ-034 cluster_offset 0 treated as 3.
REQ-035 done, valid_directory, valid_cluster, fifo_wr never high more than one consecutive cycle.

Reset
REQ-036 rst asynchronously forces state BOOT; sd_rd, done, valid_*, fifo_wr = 0; sd_address, directory_data, cluster_data, fifo_byte, index, collected = 0.
REQ-037 rst mid-STREAM abandons the sector; after release, BOOT waits for sd_ready=1 before the single done pulse.

Configuration
REQ-038 Macro XFER_COUNT_EN: when defined, adds outputs sectors_read[15:0] (increments at each FINISH, wraps at 65535->0) and dropped_req[7:0] (increments per ignored valid_address, saturates at 255), both reset to 0; when undefined, ports and logic absent, all other behaviour identical.

Verification
REQ-039 Reset release, sd_ready=1 at cycle 3 -> exactly one done pulse, state IDLE, sd_rd=0.
REQ-040 selector 0, SDaddress 0x10C000, bytes 26/27 = 0x05/0x00 -> sd_address=0x10C000, valid_directory+done same cycle, directory_data=0x0500.
REQ-041 selector 1, target 3, offset 3, bytes 3..5 = 0x34,0x12,0xF0 -> valid_cluster, cluster_data=0x3412F0.
REQ-042 Straddle: selector 1 target 510 offset 2 (0xAB,0xCD) -> done only; then selector 1 target 0 offset 1 (0xEF) -> valid_cluster, cluster_data=0xABCDEF.
REQ-043 selector 2, bytes 0..511 = index[7:0] -> 512 fifo_wr pulses, values 0x00..0xFF twice, then one done.
REQ-044 valid_address during STREAM -> ignored, current sector completes normally; with XFER_COUNT_EN, dropped_req=1.
